// File: rtl/digit_wr_arb.sv
// Write arbiter for the 7-segment digit registers: round-robin req/ack sharing of
// the single load path between two requesters, plus a self-timed clear sweep.
module digit_wr_arb #(
    parameter int             NDIG    = 8,
    parameter int             W       = 5,
    parameter logic [W-1:0]   CLR_VAL = '0,
    parameter int             AW      = $clog2(NDIG)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [1:0]        req,
    input  logic [AW-1:0]     addr0,
    input  logic [AW-1:0]     addr1,
    input  logic [W-1:0]      data0,
    input  logic [W-1:0]      data1,
    input  logic              clr,
    output logic [1:0]        ack,
    output logic [NDIG-1:0]   lden,
    output logic [W-1:0]      d,
    output logic              clr_done,
    output logic              busy
);

    typedef enum logic [1:0] {S_IDLE, S_WRITE, S_RELEASE, S_CLEAR} state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_pri;
    logic               r_gnt;
    logic               r_clr_pend;
    logic [AW-1:0]      r_k;
    logic [1:0]         r_ack;
    logic [NDIG-1:0]    r_lden;
    logic [W-1:0]       r_d;
    logic               r_clr_done;
    logic               r_busy;

    logic               w_gnt;
    logic               w_clr_any;
    logic [AW-1:0]      w_k_nxt;
    logic [AW-1:0]      w_addr;
    logic [W-1:0]       w_data;
    logic [1:0]         w_ack_nxt;
    logic [NDIG-1:0]    w_lden_nxt;
    logic [W-1:0]       w_d_nxt;
    logic               w_done_nxt;
    logic               w_busy_nxt;

    // Out-of-range addresses decode to no enable at all.
    function automatic logic [NDIG-1:0] f_onehot(input logic [AW-1:0] a);
        logic [NDIG-1:0] v;
        v = '0;
        for (int i = 0; i < NDIG; i++) begin
            if (a == AW'(i)) v[i] = 1'b1;
        end
        return v;
    endfunction

    // A clr arriving on the deciding edge counts as already pending.
    assign w_clr_any = r_clr_pend | clr;
    assign w_k_nxt   = (r_state == S_CLEAR) ? r_k + 1'b1 : '0;

    always_comb begin
        w_gnt = r_pri;
        if (req == 2'b01)      w_gnt = 1'b0;
        else if (req == 2'b10) w_gnt = 1'b1;
        w_addr = w_gnt ? addr1 : addr0;
        w_data = w_gnt ? data1 : data0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_pri      <= 1'b0;
            r_gnt      <= 1'b0;
            r_clr_pend <= 1'b0;
            r_k        <= '0;
            r_ack      <= '0;
            r_lden     <= '0;
            r_d        <= '0;
            r_clr_done <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_k     <= w_k_nxt;
            if (r_state == S_IDLE && w_state_nxt == S_CLEAR)
                r_clr_pend <= 1'b0;
            else if (clr)
                r_clr_pend <= 1'b1;
            if (r_state == S_IDLE && w_state_nxt == S_WRITE) begin
                r_gnt <= w_gnt;
                r_pri <= ~w_gnt;
            end
            r_ack      <= w_ack_nxt;
            r_lden     <= w_lden_nxt;
            r_d        <= w_d_nxt;
            r_clr_done <= w_done_nxt;
            r_busy     <= w_busy_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_clr_any)  w_state_nxt = S_CLEAR;
                else if (|req)  w_state_nxt = S_WRITE;
            end
            S_WRITE:   w_state_nxt = S_RELEASE;
            S_RELEASE: if (!req[r_gnt]) w_state_nxt = S_IDLE;
            S_CLEAR:   if (r_k == AW'(NDIG - 1)) w_state_nxt = S_IDLE;
            default:   w_state_nxt = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they are valid in that state's cycle.
    always_comb begin
        w_ack_nxt  = '0;
        w_lden_nxt = '0;
        w_d_nxt    = '0;
        w_done_nxt = 1'b0;
        w_busy_nxt = (w_state_nxt != S_IDLE);
        case (w_state_nxt)
            S_WRITE: begin
                w_ack_nxt  = w_gnt ? 2'b10 : 2'b01;
                w_lden_nxt = f_onehot(w_addr);
                w_d_nxt    = w_data;
            end
            S_CLEAR: begin
                w_lden_nxt = f_onehot(w_k_nxt);
                w_d_nxt    = CLR_VAL;
                w_done_nxt = (w_k_nxt == AW'(NDIG - 1));
            end
            default: ;
        endcase
    end

    assign ack      = r_ack;
    assign lden     = r_lden;
    assign d        = r_d;
    assign clr_done = r_clr_done;
    assign busy     = r_busy;

endmodule

// File: doc/digit_wr_arb.md
# digit_wr_arb

Write arbiter and sequencer for the eight 5-bit display digit registers (4-bit hex code plus decimal point) that feed the 7-segment display controller. It shares the single digit-register load path between two requesters using a four-phase req/ack handshake with round-robin priority. It also runs a self-timed clear sequence that writes a fixed value into every digit. Outputs drive the per-digit load enables (`lden`) and the shared data input (`d`) of the digit registers directly.

## Interface
Parameters:
- `NDIG`, default 8: number of digit registers.
- `W`, default 5: digit width, `{hex[3:0], dp}`.
- `CLR_VAL`, default 5'b00000: value written to each digit by the clear sequence.
- `AW`, default $clog2(NDIG): digit address width (derived parameter).

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  system clock (100 MHz).
- `reset_n`  in  1  asynchronous active-low reset.
- `req`  in  2  write request, one bit per requester; level, held until ack.
- `addr0` / `addr1`  in  AW  target digit index for requester 0 / 1.
- `data0` / `data1`  in  W  digit value for requester 0 / 1.
- `clr`  in  1  single-cycle clear request pulse.
- `ack`  out  2  one-cycle grant/complete pulse per requester.
- `lden`  out  NDIG  one-hot digit load enable; all zero when idle.
- `d`  out  W  shared digit data bus.
- `clr_done`  out  1  one-cycle pulse on the last clear write.
- `busy`  out  1  high whenever the state is not IDLE.

## Operation
- States: IDLE, WRITE, RELEASE, CLEAR.
- `clr_pend` is a sticky flag. It is set by `clr`=1 on any edge and cleared on entry to CLEAR. A `clr` pulse during CLEAR sets it again, so a second full clear follows.
- IDLE decision, in priority order:
  - `clr_pend` → CLEAR, digit counter 0.
  - Else if any `req` → grant by round-robin pointer `pri`. Latch `gnt`, the granted addr, and the granted data, then go to WRITE.
  - Else stay in IDLE.
- Round-robin: if only one `req` bit is set, that requester wins. If both are set, `pri` wins. After each grant, `pri` switches to the other requester. Reset value of `pri` is requester 0.
- WRITE (one cycle): `lden` = one-hot(latched addr), `d` = latched data, `ack[gnt]`=1. Next state is RELEASE.
- RELEASE: wait until `req[gnt]`=0, then go to IDLE. The other requester is not served until the next IDLE cycle. `clr_pend` keeps accumulating meanwhile.
- CLEAR: counter `k` runs from 0 to NDIG-1, one digit per cycle.
  - Each cycle: `lden` = one-hot(k), `d` = CLR_VAL.
  - At k=NDIG-1: `clr_done`=1, next state IDLE.
- An address ≥ NDIG (only possible when NDIG is not a power of 2) produces `lden`=0, but the request is still acked.
- `data0`/`data1`/`addr*` changes after the grant have no effect; values are latched.
- Reset (async assertion, any state, including mid-CLEAR or mid-WRITE):
  - State IDLE, `pri`=0, `clr_pend`=0, `k`=0.
  - `lden`=0, `d`=0, `ack`=0, `clr_done`=0, `busy`=0.
  - An interrupted clear is not resumed.

## Timing
- All outputs are registered, decoded from next-state at the clock edge.
- `req` sampled high at edge E0 in IDLE → during cycle E0–E1: `lden`, `d`, and `ack` valid and `busy`=1. The digit register loads at E1.
- Minimum handshake turnaround for one requester is 3 cycles: WRITE, RELEASE with req low, IDLE.
- Back-to-back service of the other requester (its req held): 3 cycles between successive `ack` pulses, provided the first requester drops req in the cycle it sees `ack`.
- Clear occupies exactly NDIG consecutive cycles of `lden` activity, starting the cycle after the IDLE edge that sees `clr_pend`. `clr_done` coincides with `lden[NDIG-1]`.
- `busy` is high from the first WRITE/CLEAR cycle through the last RELEASE/CLEAR cycle.

## Test plan
- **Reset:** assert `reset_n`=0 mid-cycle. Required: `lden`=0, `d`=0, `ack`=0, `clr_done`=0, `busy`=0 immediately, without waiting for a clock edge.
- **Single write:** `req`=01, `addr0`=3, `data0`=5'h15 → one cycle with `lden`=8'h08, `d`=5'h15, `ack`=01. With `req` held, no further ack. After req drops for one cycle and rises again, exactly one new ack.
- **Round-robin:** after reset, hold `req`=11 with both requesters dropping req on their ack and re-raising it. Required ack order: 01, 10, 01, 10. Each write carries its own requester's addr/data.
- **Clear with contention:** `clr` pulse and `req`=01 on the same edge → `lden` = 01, 02, 04 … 80 on 8 consecutive cycles with `d`=0, and `clr_done` with `lden`=80. Then requester 0 is written.
- **Clear during clear:** `clr` pulse at k=4 → a second full 8-cycle sweep follows, with exactly 2 `clr_done` pulses in total.
- **Reset mid-clear:** `reset_n` low at k=4 → `lden`=0 at once. After release, no further `lden` and no `clr_done` without a new `clr`.
